id_ex_stage: RTL
================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register for the 5-stage MIPS core, directly downstream of main control.
//  Latches decoded control and ID operands into EX, and detects load-use hazards.
//  Inserts a single bubble for a load-use hazard and also on branch flush.
//  Drives the stall to the PC/IF-ID. Keeps a saturating stall-cycle counter for perf.
// PARAMETERS
//  DW          32  datapath width (operands, immediate, pc+4)
//  STALL_CNT_W 16  width of the saturating stall counter
// PORTS
//  clk            in   1   core clock, rising edge
//  reset          in   1   asynchronous, active-high; clears all state immediately
//  id_valid       in   1   IF/ID holds a real instruction (0 = bubble)
//  id_reg_dst     in   1   main-control RegDst
//  id_branch      in   1   main-control Branch
//  id_mem_read    in   1   main-control MemRead
//  id_memto_reg   in   1   main-control MemtoReg
//  id_mem_write   in   1   main-control MemWrite
//  id_alu_src     in   1   main-control AluSrc
//  id_reg_write   in   1   main-control RegWrite
//  id_alu_op      in   4   main-control ALUop
//  id_rs_data     in   DW  register-file read port A
//  id_rt_data     in   DW  register-file read port B
//  id_imm         in   DW  sign-extended immediate
//  id_pc4         in   DW  pc+4 of ID instruction
//  id_rs,id_rt,id_rd in 5  register specifiers
//  id_funct       in   6   funct field
//  flush          in   1   branch taken; squash ID instruction
//  stall          out  1   hold PC and IF/ID this cycle (combinational)
//  ex_valid       out  1   EX holds real instruction
//  ex_<ctrl>      out  1/4 registered copies of the 8 control inputs
//  ex_rs_data,ex_rt_data,ex_imm,ex_pc4  out DW  registered operands
//  ex_rs,ex_rt    out  5   registered specifiers (forwarding unit)
//  ex_wr_reg      out  5   registered destination: reg_dst ? rd : rt
//  ex_funct       out  6   registered funct
//  stall_count    out  STALL_CNT_W  saturating count of stall cycles
// BEHAVIOUR
//  - Reset (async): every ex_* output = 0, stall_count = 0. stall = 0 while reset is high.
//  - uses_rt = ~id_alu_src | id_mem_write (covers R-type, beq, sw).
//  - load_use = ex_valid & ex_mem_read & (ex_wr_reg!=0) & id_valid
//      & (ex_wr_reg==id_rs | (uses_rt & ex_wr_reg==id_rt)).
//  - stall = load_use & ~flush. Combinational, same cycle, 0 latency.
//  - Each posedge, by priority:
//    1. flush | ~id_valid | load_use -> bubble: ex_valid=0, all ctrl=0, ex_alu_op=0,
//       data/specifier fields=0.
//    2. else capture: ex_valid=1; all fields take ID values; 1-cycle latency.
//  - Sanitising on capture: ex_reg_dst = id_reg_dst & id_reg_write.
//    ex_wr_reg = id_reg_write ? (id_reg_dst ? id_rd : id_rt) : 0.
//    Reason: main control leaves RegDst stale for sw/beq.
//  - Exactly one bubble per load-use: after the bubble, ex_mem_read=0, so stall drops.
//  - flush and load_use together: flush wins, stall=0, one bubble.
//  - stall_count increments on every cycle with stall=1. Saturates at all-ones, never wraps.
//  - Reset mid-stall: stall drops with reset. First post-reset cycle sees ex_valid=0.
// STRUCTURE
//  - Shared include mips_defs.vh: opcode constants (R_TYPE, LW, SW, BEQ, ADDI, ANDI, ORI, SLTI).
//  - mips_defs.vh also holds ALUop encodings (ADD 0000, SUB 0001, RTYPE 0010, AND 0011,
//    OR 0100, SLT 0101), REG_W=5, and CTRL_W=11 control-bundle bit positions.
//  - Sub-module id_ex_hazard: combinational load-use compare, outputs load_use.
//  - Top level contains the register bank, sanitising logic and counter.
// TESTING
//  1. Reset high mid-run with ex_reg_write=1 -> all ex_* 0 immediately (async);
//     stall_count=0.
//  2. R-type add rd=3,rs=1,rt=2 -> next cycle: ex_valid=1, ex_wr_reg=3,
//     ex_alu_op=0010, stall=0.
//  3. lw $5,0($1), then add $6,$5,$2 -> stall=1 for exactly 1 cycle, one bubble.
//     Add reaches EX a cycle later; stall_count=1.
//  4. lw $5 then sw $5,4($7) (uses rt) -> stall=1.
//     lw $0 then add using $0 -> stall=0.
//  5. lw $5 followed by dependent add with flush=1 same cycle -> stall=0; EX bubble
//     (ex_valid=0, ex_reg_write=0).
//  6. sw after R-type with stale id_reg_dst=1 -> ex_reg_dst=0, ex_wr_reg=0.
//     Force STALL_CNT_W=2, 5 stalls -> stall_count=3 (saturates).

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage_pkg
// Description : Shared MIPS definitions for the ID/EX stage: opcodes, ALUop
//               encodings, register-specifier width and the bit positions of
//               the registered control bundle.
// Revision    : 1.0 - initial release
// ============================================================================
package id_ex_stage_pkg;

    // Primary opcodes
    localparam logic [5:0] c_op_r_type = 6'h00;
    localparam logic [5:0] c_op_lw     = 6'h23;
    localparam logic [5:0] c_op_sw     = 6'h2b;
    localparam logic [5:0] c_op_beq    = 6'h04;
    localparam logic [5:0] c_op_addi   = 6'h08;
    localparam logic [5:0] c_op_andi   = 6'h0c;
    localparam logic [5:0] c_op_ori    = 6'h0d;
    localparam logic [5:0] c_op_slti   = 6'h0a;

    // ALUop encodings from main control
    localparam logic [3:0] c_aluop_add   = 4'b0000;
    localparam logic [3:0] c_aluop_sub   = 4'b0001;
    localparam logic [3:0] c_aluop_rtype = 4'b0010;
    localparam logic [3:0] c_aluop_and   = 4'b0011;
    localparam logic [3:0] c_aluop_or    = 4'b0100;
    localparam logic [3:0] c_aluop_slt   = 4'b0101;

    localparam int c_reg_w  = 5;
    localparam int c_ctrl_w = 11;

    // Control bundle layout; ALUop occupies the top four bits
    localparam int c_ctrl_reg_dst   = 0;
    localparam int c_ctrl_branch    = 1;
    localparam int c_ctrl_mem_read  = 2;
    localparam int c_ctrl_memto_reg = 3;
    localparam int c_ctrl_mem_write = 4;
    localparam int c_ctrl_alu_src   = 5;
    localparam int c_ctrl_reg_write = 6;
    localparam int c_ctrl_alu_op_lsb = 7;

    // Instruction reads rt as a source: R-type and beq (no immediate) and sw (store data)
    function automatic logic uses_rt(input logic alu_src, input logic mem_write);
        return ~alu_src | mem_write;
    endfunction

endpackage
`default_nettype wire

// File: rtl/id_ex_hazard.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_hazard
// Description : Combinational load-use detector. Flags when the load in EX
//               writes a register the instruction in ID is about to read.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_hazard
    import id_ex_stage_pkg::*;
(
    input  logic               ex_valid,
    input  logic               ex_mem_read,
    input  logic [c_reg_w-1:0] ex_wr_reg,
    input  logic               id_valid,
    input  logic [c_reg_w-1:0] id_rs,
    input  logic [c_reg_w-1:0] id_rt,
    input  logic               id_alu_src,
    input  logic               id_mem_write,
    output logic               load_use
);

    logic w_rs_hit;
    logic w_rt_hit;

    // $0 is never a real dependency, so a zero destination never matches
    always_comb begin
        w_rs_hit = (ex_wr_reg == id_rs);
        w_rt_hit = uses_rt(id_alu_src, id_mem_write) & (ex_wr_reg == id_rt);
        load_use = ex_valid & ex_mem_read & (ex_wr_reg != '0) & id_valid
                   & (w_rs_hit | w_rt_hit);
    end

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage
// Description : ID/EX pipeline register. Captures sanitised control and
//               operands, inserts a bubble on load-use or flush, drives the
//               PC/IF-ID stall and counts stall cycles (saturating).
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DW          = 32,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   id_valid,
    input  logic                   id_reg_dst,
    input  logic                   id_branch,
    input  logic                   id_mem_read,
    input  logic                   id_memto_reg,
    input  logic                   id_mem_write,
    input  logic                   id_alu_src,
    input  logic                   id_reg_write,
    input  logic [3:0]             id_alu_op,
    input  logic [DW-1:0]          id_rs_data,
    input  logic [DW-1:0]          id_rt_data,
    input  logic [DW-1:0]          id_imm,
    input  logic [DW-1:0]          id_pc4,
    input  logic [c_reg_w-1:0]     id_rs,
    input  logic [c_reg_w-1:0]     id_rt,
    input  logic [c_reg_w-1:0]     id_rd,
    input  logic [5:0]             id_funct,
    input  logic                   flush,
    output logic                   stall,
    output logic                   ex_valid,
    output logic                   ex_reg_dst,
    output logic                   ex_branch,
    output logic                   ex_mem_read,
    output logic                   ex_memto_reg,
    output logic                   ex_mem_write,
    output logic                   ex_alu_src,
    output logic                   ex_reg_write,
    output logic [3:0]             ex_alu_op,
    output logic [DW-1:0]          ex_rs_data,
    output logic [DW-1:0]          ex_rt_data,
    output logic [DW-1:0]          ex_imm,
    output logic [DW-1:0]          ex_pc4,
    output logic [c_reg_w-1:0]     ex_rs,
    output logic [c_reg_w-1:0]     ex_rt,
    output logic [c_reg_w-1:0]     ex_wr_reg,
    output logic [5:0]             ex_funct,
    output logic [STALL_CNT_W-1:0] stall_count
);

    logic [c_ctrl_w-1:0]    w_id_ctrl;
    logic [c_reg_w-1:0]     w_id_wr_reg;
    logic                   w_load_use;
    logic                   w_bubble;
    logic                   w_stall;

    logic                   r_ex_valid;
    logic [c_ctrl_w-1:0]    r_ex_ctrl;
    logic [DW-1:0]          r_ex_rs_data;
    logic [DW-1:0]          r_ex_rt_data;
    logic [DW-1:0]          r_ex_imm;
    logic [DW-1:0]          r_ex_pc4;
    logic [c_reg_w-1:0]     r_ex_rs;
    logic [c_reg_w-1:0]     r_ex_rt;
    logic [c_reg_w-1:0]     r_ex_wr_reg;
    logic [5:0]             r_ex_funct;
    logic [STALL_CNT_W-1:0] r_stall_count;

    id_ex_hazard u_hazard (
        .ex_valid     (r_ex_valid),
        .ex_mem_read  (r_ex_ctrl[c_ctrl_mem_read]),
        .ex_wr_reg    (r_ex_wr_reg),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_alu_src   (id_alu_src),
        .id_mem_write (id_mem_write),
        .load_use     (w_load_use)
    );

    // Sanitise control: main control leaves RegDst stale on sw/beq, so a
    // non-writing instruction never carries a destination into EX
    always_comb begin
        w_id_ctrl   = {id_alu_op, id_reg_write, id_alu_src, id_mem_write,
                       id_memto_reg, id_mem_read, id_branch,
                       id_reg_dst & id_reg_write};
        w_id_wr_reg = id_reg_write ? (id_reg_dst ? id_rd : id_rt) : '0;
        w_bubble    = flush | ~id_valid | w_load_use;
        w_stall     = w_load_use & ~flush & ~reset;
    end

    // Pipeline register: bubble (all zero) or capture of the ID instruction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ex_valid   <= 1'b0;
            r_ex_ctrl    <= '0;
            r_ex_rs_data <= '0;
            r_ex_rt_data <= '0;
            r_ex_imm     <= '0;
            r_ex_pc4     <= '0;
            r_ex_rs      <= '0;
            r_ex_rt      <= '0;
            r_ex_wr_reg  <= '0;
            r_ex_funct   <= '0;
        end else if (w_bubble) begin
            r_ex_valid   <= 1'b0;
            r_ex_ctrl    <= '0;
            r_ex_rs_data <= '0;
            r_ex_rt_data <= '0;
            r_ex_imm     <= '0;
            r_ex_pc4     <= '0;
            r_ex_rs      <= '0;
            r_ex_rt      <= '0;
            r_ex_wr_reg  <= '0;
            r_ex_funct   <= '0;
        end else begin
            r_ex_valid   <= 1'b1;
            r_ex_ctrl    <= w_id_ctrl;
            r_ex_rs_data <= id_rs_data;
            r_ex_rt_data <= id_rt_data;
            r_ex_imm     <= id_imm;
            r_ex_pc4     <= id_pc4;
            r_ex_rs      <= id_rs;
            r_ex_rt      <= id_rt;
            r_ex_wr_reg  <= w_id_wr_reg;
            r_ex_funct   <= id_funct;
        end
    end

    // Stall-cycle counter, holds at all-ones instead of wrapping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_count <= '0;
        end else if (w_stall && (r_stall_count != {STALL_CNT_W{1'b1}})) begin
            r_stall_count <= r_stall_count + 1'b1;
        end
    end

    assign stall        = w_stall;
    assign ex_valid     = r_ex_valid;
    assign ex_reg_dst   = r_ex_ctrl[c_ctrl_reg_dst];
    assign ex_branch    = r_ex_ctrl[c_ctrl_branch];
    assign ex_mem_read  = r_ex_ctrl[c_ctrl_mem_read];
    assign ex_memto_reg = r_ex_ctrl[c_ctrl_memto_reg];
    assign ex_mem_write = r_ex_ctrl[c_ctrl_mem_write];
    assign ex_alu_src   = r_ex_ctrl[c_ctrl_alu_src];
    assign ex_reg_write = r_ex_ctrl[c_ctrl_reg_write];
    assign ex_alu_op    = r_ex_ctrl[c_ctrl_alu_op_lsb +: 4];
    assign ex_rs_data   = r_ex_rs_data;
    assign ex_rt_data   = r_ex_rt_data;
    assign ex_imm       = r_ex_imm;
    assign ex_pc4       = r_ex_pc4;
    assign ex_rs        = r_ex_rs;
    assign ex_rt        = r_ex_rt;
    assign ex_wr_reg    = r_ex_wr_reg;
    assign ex_funct     = r_ex_funct;
    assign stall_count  = r_stall_count;

endmodule
`default_nettype wire
